// File: rtl/regfile_dump.sv
// Register-range dump engine: walks a register file read port from
// FIRST to LAST (wrapping) and streams each word over a valid/ready port.
module regfile_dump #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] FIRST,
  input  logic [ADDR_WIDTH-1:0] LAST,
  output logic [ADDR_WIDTH-1:0] Ra,
  input  logic [DATA_WIDTH-1:0] Da,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [ADDR_WIDTH-1:0] OUT_IDX,
  output logic                  BUSY,
  output logic                  DONE
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FIN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur;
  logic [ADDR_WIDTH-1:0] stop;

  assign Ra   = cur;
  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cur       <= '0;
      stop      <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_IDX   <= '0;
      DONE      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            cur   <= FIRST;
            stop  <= LAST;
            state <= READ;
          end
        end
        READ: begin
          OUT_DATA  <= Da;
          OUT_IDX   <= cur;
          OUT_VALID <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            if (cur == stop) begin
              DONE  <= 1'b1;
              state <= FIN;
            end else begin
              // index wraps naturally at the register count
              cur   <= cur + 1'b1;
              state <= READ;
            end
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register index width (32 registers).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port START  input  1  request to dump a register range; sampled only in IDLE.
REQ-006 SHALL have port FIRST  input  ADDR_WIDTH  first register index of the range; sampled with START.
REQ-007 SHALL have port LAST  input  ADDR_WIDTH  last register index of the range; sampled with START.
REQ-008 SHALL have port Ra  output  ADDR_WIDTH  read address to the register file read port.
REQ-009 SHALL have port Da  input  DATA_WIDTH  combinational read data from the register file for Ra.
REQ-010 SHALL have port OUT_VALID  output  1  OUT_DATA/OUT_IDX hold a valid word.
REQ-011 SHALL have port OUT_READY  input  1  consumer accepts the word when OUT_VALID and OUT_READY are both high on a rising edge.
REQ-012 SHALL have port OUT_DATA  output  DATA_WIDTH  captured register value.
REQ-013 SHALL have port OUT_IDX  output  ADDR_WIDTH  index of the register in OUT_DATA.
REQ-014 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-016 SHALL implement states IDLE, READ, SEND, FIN.
REQ-017 IDLE: on START=1, SHALL latch cur<=FIRST, last<=LAST and move to READ; otherwise stay in IDLE.
REQ-018 Ra SHALL equal the cur register in every state (Ra=0 in IDLE after reset).
REQ-019 READ (one cycle): SHALL capture OUT_DATA<=Da and OUT_IDX<=cur, set OUT_VALID<=1, and move to SEND.
REQ-020 SEND: while OUT_READY=0, SHALL hold OUT_VALID, OUT_DATA and OUT_IDX stable.
REQ-021 SEND with OUT_READY=1: SHALL clear OUT_VALID; if cur==last, SHALL go to FIN; else SHALL set cur<=cur+1 and go to READ.
REQ-022 The index increment SHALL be modulo 2^ADDR_WIDTH, so 31+1 wraps to 0.
REQ-023 If FIRST>LAST, the dump SHALL wrap through 31 to 0 and end at LAST; word count = ((LAST-FIRST) mod 32)+1.
REQ-024 If FIRST==LAST, exactly one word SHALL be sent.
REQ-025 FIN: SHALL assert DONE for exactly one cycle, then return to IDLE.
REQ-026 START SHALL be ignored in READ, SEND and FIN, and in the FIN cycle itself.
REQ-027 A new dump SHALL be accepted in the first IDLE cycle after FIN.
REQ-028 Throughput SHALL be at most one word per two cycles.
REQ-029 Latency from START to the first OUT_VALID=1 SHALL be two rising edges.
REQ-030 Changes to FIRST/LAST during a dump SHALL have no effect.
REQ-031 The block SHALL never write the register file; index 0 SHALL be dumped as whatever Da returns.

Reset
REQ-032 RST=1 SHALL asynchronously force state=IDLE, cur=0, last=0, OUT_VALID=0, OUT_DATA=0, OUT_IDX=0, DONE=0, BUSY=0.
REQ-033 Reset asserted mid-dump SHALL abort it with no DONE pulse; the first START after RST deasserts SHALL begin a fresh dump.

Verification
REQ-034 Write x1=234, x2=672 to the regfile; START with FIRST=1, LAST=2, OUT_READY=1 -> words (1,234), (2,672), then one DONE pulse, then BUSY=0.
REQ-035 START with FIRST=30, LAST=1 -> OUT_IDX sequence 30,31,0,1 with OUT_DATA 0 at index 0, and 4 words total.
REQ-036 Hold OUT_READY=0 for 5 cycles after the first OUT_VALID -> OUT_DATA/OUT_IDX stay constant and Ra does not advance; the word is accepted on the first edge with OUT_READY=1.
REQ-037 START with FIRST=LAST=18 (x18=672) -> single word (18,672); DONE is high exactly 3 edges after START with OUT_READY=1.
REQ-038 Pulse START again during a dump of 1..4 -> the dump is unaffected (4 words); assert RST during the 2nd word -> OUT_VALID=0 and BUSY=0 immediately, with no DONE.
